// File: rtl/alu_result_display.sv
// Shows the 8-bit ALU result on a 4-digit multiplexed seven-segment display, in decimal or hex.
// The digits are rebuilt after each input change, and the carry and zero flags are also shown.
module alu_result_display #(
  parameter int SCAN_DIV = 25000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] RESULT,
  input  logic       ZERO,
  input  logic       CARRY,
  input  logic       MODE,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN,
  output logic       BUSY
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic [4:0] CODE_H     = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;
  localparam logic [4:0] CODE_C     = 5'd18;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t      state, state_next;
  logic [7:0]  snap_val;
  logic        snap_mode;
  logic [7:0]  shreg;
  logic [11:0] bcd;
  logic [2:0]  iter;
  logic [4:0]  d2, d1, d0;
  logic        carry_q, zero_q;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  digit_idx;

  logic        changed, capture, shift_en, load_en;
  logic [3:0]  tens_adj, units_adj;
  logic [4:0]  cur_code;

  assign changed = (RESULT != snap_val) || (MODE != snap_mode);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = MODE ? LOAD : CONVERT;
      CONVERT: if (iter == 3'd7) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state != IDLE);
    capture  = (state == IDLE) && changed;
    shift_en = (state == CONVERT);
    load_en  = (state == LOAD);
  end

  // Hundreds never exceeds 2 for an 8-bit input, so only tens and units need the add-3 step.
  assign tens_adj  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
  assign units_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_val  <= 8'd0;
      snap_mode <= 1'b0;
      shreg     <= 8'd0;
      bcd       <= 12'd0;
      iter      <= 3'd0;
      d2        <= CODE_BLANK;
      d1        <= CODE_BLANK;
      d0        <= 5'd0;
    end else begin
      if (capture) begin
        snap_val  <= RESULT;
        snap_mode <= MODE;
        shreg     <= RESULT;
        bcd       <= 12'd0;
        iter      <= 3'd0;
      end
      if (shift_en) begin
        bcd   <= {bcd[10:8], tens_adj, units_adj, shreg[7]};
        shreg <= {shreg[6:0], 1'b0};
        iter  <= iter + 3'd1;
      end
      if (load_en) begin
        if (snap_mode) begin
          d2 <= CODE_H;
          d1 <= {1'b0, snap_val[7:4]};
          d0 <= {1'b0, snap_val[3:0]};
        end else begin
          d2 <= (bcd[11:8] == 4'd0) ? CODE_BLANK : {1'b0, bcd[11:8]};
          d1 <= (bcd[11:4] == 8'd0) ? CODE_BLANK : {1'b0, bcd[7:4]};
          d0 <= {1'b0, bcd[3:0]};
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= CARRY;
      zero_q  <= ZERO;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    case (digit_idx)
      2'd0:    cur_code = d0;
      2'd1:    cur_code = d1;
      2'd2:    cur_code = d2;
      default: cur_code = carry_q ? CODE_C : CODE_BLANK;
    endcase
  end

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    case (code)
      5'd0:    return 7'b1000000;
      5'd1:    return 7'b1111001;
      5'd2:    return 7'b0100100;
      5'd3:    return 7'b0110000;
      5'd4:    return 7'b0011001;
      5'd5:    return 7'b0010010;
      5'd6:    return 7'b0000010;
      5'd7:    return 7'b1111000;
      5'd8:    return 7'b0000000;
      5'd9:    return 7'b0010000;
      5'd10:   return 7'b0001000;
      5'd11:   return 7'b0000011;
      5'd12:   return 7'b1000110;
      5'd13:   return 7'b0100001;
      5'd14:   return 7'b0000110;
      5'd15:   return 7'b0001110;
      CODE_H:  return 7'b0001011;
      CODE_C:  return 7'b1000110;
      default: return 7'b1111111;
    endcase
  endfunction

  // AN, SEG and DP are all loaded from the same digit index, so they switch together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN  <= 4'b1111;
      SEG <= 7'b1111111;
      DP  <= 1'b1;
    end else begin
      AN  <= ~(4'b0001 << digit_idx);
      SEG <= seg_decode(cur_code);
      DP  <= ~(zero_q && (digit_idx == 2'd0));
    end
  end

endmodule
